// File: rtl/brick_field.sv
// Breakout brick wall: hit-edge detection, scoring, level clear/refill, and a registered brick pixel renderer.
// Optional build macro BRICK_BORDER_EN draws a 1-pixel white outline on every visible brick.
module brick_field #(
   parameter int NUM_X        = 14,
   parameter int NUM_Y        = 4,
   parameter int BLOCK_W      = 40,
   parameter int BLOCK_H      = 20,
   parameter int SPACING      = 5,
   parameter int START_X      = 152,
   parameter int START_Y      = 150,
   parameter int CLEAR_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  hCount,
   input  logic [9:0]  vCount,
   input  logic [55:0] hit_mask_in,
   output logic [55:0] visible,
   output logic        block_on,
   output logic [11:0] block_pixel,
   output logic [15:0] score,
   output logic [3:0]  level,
   output logic        level_clear
);

   localparam int NUM_BRICKS = NUM_X * NUM_Y;
   localparam int IDX_W      = $clog2(NUM_BRICKS);
   localparam int CNT_W      = $clog2(CLEAR_CYCLES + 1);

   typedef enum logic [1:0] {PLAY, CLEAR_HOLD, REFILL} state_t;

   state_t               state, state_next;
   logic [CNT_W-1:0]     hold_cnt;
   logic [NUM_BRICKS-1:0] hit_prev;
   logic [NUM_BRICKS-1:0] newly;

   logic [10:0]          x0, y0;
   logic                 col_hit, row_hit;
   int                   col_i, row_i;
   logic [IDX_W-1:0]     idx;
   logic                 on_next;
   logic [11:0]          pix_next;
`ifdef BRICK_BORDER_EN
   logic                 edge_x, edge_y;
`endif

   function automatic logic [5:0] popcount(input logic [NUM_BRICKS-1:0] v);
      logic [5:0] cnt;
      cnt = '0;
      for (int i = 0; i < NUM_BRICKS; i++) cnt = cnt + 6'(v[i]);
      return cnt;
   endfunction

   function automatic logic [15:0] sat_add(input logic [15:0] s, input logic [5:0] n);
      logic [16:0] sum;
      sum = {1'b0, s} + {11'b0, n};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   function automatic logic [11:0] row_colour(input int r);
      case (r)
         0:       return 12'hF00;
         1:       return 12'hF80;
         2:       return 12'hFF0;
         default: return 12'h0F0;
      endcase
   endfunction

   // A brick counts only on the cycle its hit bit falls, and only if still standing.
   assign newly = hit_prev & ~hit_mask_in & visible;

   always_ff @(posedge clk) begin
      if (rst) state <= PLAY;
      else     state <= state_next;
   end

   always_comb begin
      state_next  = state;
      level_clear = 1'b0;
      case (state)
         PLAY:       if (visible == '0) state_next = CLEAR_HOLD;
         CLEAR_HOLD: begin
            level_clear = 1'b1;
            if (hold_cnt == CNT_W'(CLEAR_CYCLES - 1)) state_next = REFILL;
         end
         REFILL:     state_next = PLAY;
         default:    state_next = PLAY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         visible  <= '1;
         hit_prev <= '1;
         score    <= '0;
         level    <= '0;
         hold_cnt <= '0;
      end else begin
         hit_prev <= hit_mask_in;
         case (state)
            PLAY: begin
               visible  <= visible & ~newly;
               score    <= sat_add(score, popcount(newly));
               hold_cnt <= '0;
            end
            CLEAR_HOLD: hold_cnt <= hold_cnt + 1'b1;
            REFILL: begin
               visible <= '1;
               if (level != 4'hF) level <= level + 4'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      x0       = '0;
      y0       = '0;
      col_hit  = 1'b0;
      row_hit  = 1'b0;
      col_i    = 0;
      row_i    = 0;
      on_next  = 1'b0;
      pix_next = '0;
`ifdef BRICK_BORDER_EN
      edge_x   = 1'b0;
      edge_y   = 1'b0;
`endif
      for (int c = 0; c < NUM_X; c++) begin
         x0 = 11'(START_X + c * (BLOCK_W + SPACING));
         if ({1'b0, hCount} >= x0 && {1'b0, hCount} < x0 + 11'(BLOCK_W)) begin
            col_hit = 1'b1;
            col_i   = c;
`ifdef BRICK_BORDER_EN
            edge_x  = ({1'b0, hCount} == x0) || ({1'b0, hCount} == x0 + 11'(BLOCK_W - 1));
`endif
         end
      end
      for (int r = 0; r < NUM_Y; r++) begin
         y0 = 11'(START_Y + r * (BLOCK_H + SPACING));
         if ({1'b0, vCount} >= y0 && {1'b0, vCount} < y0 + 11'(BLOCK_H)) begin
            row_hit = 1'b1;
            row_i   = r;
`ifdef BRICK_BORDER_EN
            edge_y  = ({1'b0, vCount} == y0) || ({1'b0, vCount} == y0 + 11'(BLOCK_H - 1));
`endif
         end
      end
      idx = IDX_W'(row_i * NUM_X + col_i);
      if (col_hit && row_hit && visible[idx]) begin
         on_next  = 1'b1;
         pix_next = row_colour(row_i);
`ifdef BRICK_BORDER_EN
         if (edge_x || edge_y) pix_next = 12'hFFF;
`endif
      end
   end

   // Pixel stage: outputs reflect the coordinates sampled at the previous edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         block_on    <= 1'b0;
         block_pixel <= '0;
      end else begin
         block_on    <= on_next;
         block_pixel <= pix_next;
      end
   end

endmodule

// File: tb/tb_brick_field.sv
// Directed bench for brick_field: reset, hit scoring, wall clear/refill timing, pixel mapping, mid-run reset.
module tb_brick_field;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  hCount, vCount;
   logic [55:0] hit_mask_in;
   logic [55:0] visible;
   logic        block_on;
   logic [11:0] block_pixel;
   logic [15:0] score;
   logic [3:0]  level;
   logic        level_clear;

   int n_checks = 0;
   int n_fail   = 0;
   int lc_high;
   logic lc_seq [0:11];

   localparam logic [55:0] ALL = 56'hFF_FFFF_FFFF_FFFF;

   brick_field #(.CLEAR_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount),
      .hit_mask_in(hit_mask_in), .visible(visible), .block_on(block_on),
      .block_pixel(block_pixel), .score(score), .level(level),
      .level_clear(level_clear)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; hCount = '0; vCount = '0; hit_mask_in = ALL;
      tick(); tick();
      check("rst_visible", visible, ALL);
      check("rst_score", score, 0);
      check("rst_level", level, 0);
      check("rst_level_clear", level_clear, 0);
      check("rst_block_on", block_on, 0);
      check("rst_block_pixel", block_pixel, 0);
      rst = 1'b0;

      hCount = 10'd152; vCount = 10'd150; tick();
      check("pix_b0_on", block_on, 1);
      check("pix_b0_colour", block_pixel, 12'hF00);
      hCount = 10'd191; tick();
      check("pix_b0_lastcol", block_on, 1);
      hCount = 10'd193; tick();
      check("pix_gap_x", block_on, 0);
      check("pix_gap_x_colour", block_pixel, 0);
      hCount = 10'd152; vCount = 10'd170; tick();
      check("pix_gap_y", block_on, 0);
      vCount = 10'd225; tick();
      check("pix_row3_on", block_on, 1);
      check("pix_row3_colour", block_pixel, 12'h0F0);
      hCount = 10'd197; vCount = 10'd175; tick();
      check("pix_row1_colour", block_pixel, 12'hF80);
      hCount = 10'd800; tick();
      check("pix_outside", block_on, 0);

      hit_mask_in[0] = 1'b0; tick();
      check("hit0_visible", visible[0], 0);
      check("hit0_score", score, 1);
      repeat (9) tick();
      check("hit0_held_score", score, 1);
      hCount = 10'd152; vCount = 10'd150; tick();
      check("pix_b0_hit", block_on, 0);
      hit_mask_in[0] = 1'b1; tick();
      check("hit0_rise_score", score, 1);

      hit_mask_in[3] = 1'b0; hit_mask_in[17] = 1'b0; hit_mask_in[55] = 1'b0; tick();
      check("multi_score", score, 4);
      check("multi_visible", visible, ALL & ~56'h80_0000_0002_0009);

      hit_mask_in = '0; tick();
      check("clear_score", score, 56);
      check("clear_visible", visible, 0);
      check("clear_lc_pre", level_clear, 0);
      hit_mask_in = ALL;
      lc_high = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         lc_seq[i] = level_clear;
         if (level_clear) lc_high++;
         if (i == 0) hit_mask_in[9] = 1'b0;
         if (i == 9) begin
            check("refill_visible", visible, ALL);
            check("refill_level", level, 1);
         end
      end
      check("hold_cycles", lc_high, 8);
      check("hold_first", lc_seq[0], 1);
      check("hold_last", lc_seq[7], 1);
      check("hold_end", lc_seq[8], 0);
      check("hold_hit_ignored", score, 56);

      hit_mask_in = ALL; tick();
      hit_mask_in = '0; tick();
      check("clear2_score", score, 112);
      tick();
      check("clear2_lc", level_clear, 1);
      tick();
      rst = 1'b1; hit_mask_in = ALL; tick();
      check("midrst_lc", level_clear, 0);
      check("midrst_visible", visible, ALL);
      check("midrst_score", score, 0);
      check("midrst_level", level, 0);
      rst = 1'b0; tick(); tick();
      check("post_rst_score", score, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
